// File: rtl/serial_mux_tx.sv
// serial_mux_tx: four-channel round-robin parallel-to-serial transmitter.
// Frame on serOut: start(0), 2-bit address, DATA_W data MSB-first, stop(1).
module serial_mux_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                clk,
   input  logic                rstN,
   input  logic [4*DATA_W-1:0] chData,
   input  logic [3:0]          chValid,
   output logic [3:0]          chReady,
   output logic                serOut,
   output logic                busy,
   output logic [1:0]          curChan
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int NW = $clog2(DATA_W + 1);
   localparam int SW = DATA_W + 2;
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] DATA_MAX = NW'(DATA_W - 1);
   localparam logic [NW-1:0] ADDR_MAX = NW'(1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      ADDR,
      DATA,
      STOP
   } state_t;

   state_t state, state_nxt;

   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [NW-1:0] bit_cnt, bit_nxt;
   logic [SW-1:0] shreg, shreg_nxt;
   logic [1:0]    rr_last, grant;
   logic          grant_ok, bit_end, last_bit, xfer, ser_nxt;

   // Scan from the farthest candidate down so the nearest one wins.
   always_comb begin
      grant_ok = 1'b0;
      grant    = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         if (chValid[rr_last + 2'(k)]) begin
            grant_ok = 1'b1;
            grant    = rr_last + 2'(k);
         end
      end
   end

   assign bit_end = (baud_cnt == BAUD_MAX);
   assign busy    = (state != IDLE);

   always_comb begin
      last_bit = 1'b0;
      unique case (state)
         START:   last_bit = 1'b1;
         ADDR:    last_bit = (bit_cnt == ADDR_MAX);
         DATA:    last_bit = (bit_cnt == DATA_MAX);
         STOP:    last_bit = 1'b1;
         default: last_bit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (xfer) state_nxt = START;
         START:   if (bit_end) state_nxt = ADDR;
         ADDR:    if (bit_end && last_bit) state_nxt = DATA;
         DATA:    if (bit_end && last_bit) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      chReady = 4'b0000;
      if (rstN && state == IDLE && grant_ok)
         chReady = 4'b0001 << grant;
      xfer = |(chReady & chValid);

      baud_nxt  = '0;
      bit_nxt   = '0;
      shreg_nxt = shreg;
      if (state == IDLE) begin
         if (xfer)
            shreg_nxt = {grant, chData[grant*DATA_W +: DATA_W]};
      end else if (!bit_end) begin
         baud_nxt = baud_cnt + 1'b1;
         bit_nxt  = bit_cnt;
      end else if (!last_bit) begin
         bit_nxt = bit_cnt + 1'b1;
      end
      if (bit_end && (state == ADDR || state == DATA))
         shreg_nxt = shreg << 1;

      // serOut is registered, so it is derived from the upcoming state.
      ser_nxt = 1'b1;
      unique case (state_nxt)
         START:      ser_nxt = 1'b0;
         ADDR, DATA: ser_nxt = shreg_nxt[SW-1];
         default:    ser_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         serOut   <= 1'b1;
         rr_last  <= 2'd3;
         curChan  <= 2'd0;
      end else begin
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
         serOut   <= ser_nxt;
         if (xfer) begin
            rr_last <= grant;
            curChan <= grant;
         end
      end
   end

endmodule

// File: tb/tb_serial_mux_tx.sv
// tb_serial_mux_tx: two transmitters (1 and 3 clocks per bit) checked each
// cycle against a frame-level model, plus directed scenarios.
module tb_serial_mux_tx;

   localparam int DW = 8;
   localparam int FB = DW + 4;

   logic clk = 1'b0;
   logic rstN;

   logic [3:0]      ch_valid [2];
   logic [4*DW-1:0] ch_data  [2];
   logic [3:0]      ch_ready [2];
   logic            ser_out  [2];
   logic            busy     [2];
   logic [1:0]      cur_chan [2];

   int  m_t    [2];
   int  m_rr   [2];
   int  m_chan [2];
   bit  m_bits [2][FB];
   bit  cons   [2][4];
   bit  refill;
   bit  rand_mode;
   int  dlog0[$];
   int  dlog1[$];
   int  n_chk = 0;
   int  n_err = 0;

   always #5 clk = ~clk;

   serial_mux_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) dut_c1 (
      .clk(clk), .rstN(rstN), .chData(ch_data[0]), .chValid(ch_valid[0]),
      .chReady(ch_ready[0]), .serOut(ser_out[0]), .busy(busy[0]),
      .curChan(cur_chan[0])
   );

   serial_mux_tx #(.DATA_W(DW), .CLKS_PER_BIT(3)) dut_c3 (
      .clk(clk), .rstN(rstN), .chData(ch_data[1]), .chValid(ch_valid[1]),
      .chReady(ch_ready[1]), .serOut(ser_out[1]), .busy(busy[1]),
      .curChan(cur_chan[1])
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int cpb(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic int winner(input int rr, input logic [3:0] v);
      for (int k = 1; k <= 4; k++)
         if (v[(rr + k) % 4]) return (rr + k) % 4;
      return -1;
   endfunction

   function automatic int log_size(input int u);
      return (u == 0) ? dlog0.size() : dlog1.size();
   endfunction

   // Model: a frame is a bit list; cycle t of the frame shows bit t/CPB.
   always @(posedge clk or negedge rstN) begin
      int w;
      for (int u = 0; u < 2; u++) begin
         if (!rstN) begin
            m_t[u] = -1;
            m_rr[u] = 3;
            m_chan[u] = 0;
         end else if (m_t[u] < 0) begin
            w = winner(m_rr[u], ch_valid[u]);
            if (w >= 0) begin
               m_bits[u][0] = 1'b0;
               m_bits[u][1] = w[1];
               m_bits[u][2] = w[0];
               for (int j = 0; j < DW; j++)
                  m_bits[u][3+j] = ch_data[u][w*DW + DW-1-j];
               m_bits[u][FB-1] = 1'b1;
               m_t[u] = 0;
               m_rr[u] = w;
               m_chan[u] = w;
               cons[u][w] = 1'b1;
            end
         end else begin
            m_t[u]++;
            if (m_t[u] == FB * cpb(u)) m_t[u] = -1;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] er;
      logic       eb, es;
      logic [1:0] ec;
      int         w;
      #2;
      for (int u = 0; u < 2; u++) begin
         if (!rstN) begin
            er = 4'b0; eb = 1'b0; es = 1'b1; ec = 2'd0;
         end else if (m_t[u] < 0) begin
            w  = winner(m_rr[u], ch_valid[u]);
            er = (w >= 0) ? 4'(1 << w) : 4'b0;
            eb = 1'b0; es = 1'b1; ec = 2'(m_chan[u]);
         end else begin
            er = 4'b0; eb = 1'b1;
            es = m_bits[u][m_t[u] / cpb(u)];
            ec = 2'(m_chan[u]);
         end
         chk(u ? "c3_ready" : "c1_ready", ch_ready[u], er);
         chk(u ? "c3_busy"  : "c1_busy",  busy[u],     eb);
         chk(u ? "c3_ser"   : "c1_ser",   ser_out[u],  es);
         chk(u ? "c3_chan"  : "c1_chan",  cur_chan[u], ec);
         for (int i = 0; i < 4; i++)
            if (ch_ready[u][i] && ch_valid[u][i]) begin
               if (u == 0) dlog0.push_back(i);
               else        dlog1.push_back(i);
            end
      end
   end

   task automatic tick();
      @(negedge clk);
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < 4; i++) begin
            if (rand_mode) begin
               if (cons[u][i] || !ch_valid[u][i]) begin
                  ch_valid[u][i] = ($urandom_range(2) == 0);
                  ch_data[u][i*DW +: DW] = DW'($urandom);
               end else if ($urandom_range(40) == 0) begin
                  ch_valid[u][i] = 1'b0;
               end
            end else if (cons[u][i]) begin
               ch_valid[u][i] = refill;
               ch_data[u][i*DW +: DW] = DW'($urandom);
            end
            cons[u][i] = 1'b0;
         end
   endtask

   task automatic wait_grant(input int u, input int n, input int lim,
                             input string tag);
      int k = 0;
      #3;
      while (log_size(u) < n && k < lim) begin
         tick();
         #3;
         k++;
      end
      chk(tag, log_size(u), n);
   endtask

   initial begin
      logic [11:0] g12;
      logic [35:0] g36;
      int nb, n;
      rstN = 1'b0;
      refill = 1'b0;
      rand_mode = 1'b0;
      for (int u = 0; u < 2; u++) begin
         ch_valid[u] = 4'b0;
         ch_data[u] = '0;
         for (int i = 0; i < 4; i++) cons[u][i] = 1'b0;
      end
      repeat (3) tick();
      rstN = 1'b1;
      repeat (20) tick();

      // ch2 sends 0xA5 at one clock per bit
      ch_data[0][23:16] = 8'hA5;
      ch_valid[0] = 4'b0100;
      #1;
      chk("t2_ready", ch_ready[0], 4'b0100);
      wait_grant(0, 1, 10, "t2_grant");
      nb = 0;
      g12 = '0;
      for (int k = 0; k < 14; k++) begin
         tick();
         #1;
         if (k < 12) g12[11-k] = ser_out[0];
         nb += int'(busy[0]);
         if (k == 5) chk("t2_chan", cur_chan[0], 2);
      end
      chk("t2_bits", g12, 12'b010101001011);
      chk("t2_busy", nb, 12);

      // all channels held valid from reset
      tick();
      rstN = 1'b0;
      refill = 1'b1;
      ch_valid[0] = 4'hF;
      ch_data[0] = $urandom;
      tick();
      tick();
      rstN = 1'b1;
      n = dlog0.size();
      wait_grant(0, n + 5, 200, "t3_frames");
      for (int k = 0; k < 5; k++)
         if (n + k < dlog0.size())
            chk("t3_order", dlog0[n+k], k % 4);
      refill = 1'b0;
      ch_valid[0] = 4'b0;
      repeat (20) tick();

      // ch1 alone, then ch1 and ch3 contend
      n = dlog0.size();
      ch_valid[0] = 4'b0010;
      wait_grant(0, n + 1, 20, "t4_first");
      tick();
      ch_valid[0] = 4'b1010;
      wait_grant(0, n + 3, 100, "t4_pair");
      if (dlog0.size() >= n + 3) begin
         chk("t4_g0", dlog0[n], 1);
         chk("t4_g1", dlog0[n+1], 3);
         chk("t4_g2", dlog0[n+2], 1);
      end
      repeat (20) tick();

      // ch0 sends 0xFF at three clocks per bit
      n = dlog1.size();
      ch_data[1][7:0] = 8'hFF;
      ch_valid[1] = 4'b0001;
      wait_grant(1, n + 1, 20, "t5_grant");
      nb = 0;
      g36 = '0;
      for (int k = 0; k < 38; k++) begin
         tick();
         #1;
         if (k < 36) g36[35-k] = ser_out[1];
         nb += int'(busy[1]);
      end
      chk("t5_bits", g36, 36'h007FFFFFF);
      chk("t5_busy", nb, 36);

      // reset during the data bits of a ch3 frame
      tick();
      n = dlog0.size();
      ch_data[0][31:24] = 8'h00;
      ch_valid[0] = 4'b1000;
      wait_grant(0, n + 1, 20, "t6_grant");
      repeat (6) tick();
      #1;
      chk("t6_pre_ser", ser_out[0], 0);
      tick();
      rstN = 1'b0;
      #1;
      chk("t6_rst_ser", ser_out[0], 1);
      chk("t6_rst_busy", busy[0], 0);
      tick();
      rstN = 1'b1;
      ch_valid[0] = 4'b1001;
      wait_grant(0, n + 2, 20, "t6_after");
      if (dlog0.size() >= n + 2) chk("t6_first", dlog0[n+1], 0);
      repeat (30) tick();
      ch_valid[0] = 4'b0;
      repeat (30) tick();

      // randomized traffic with occasional resets
      rand_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         tick();
         rstN = ($urandom_range(400) != 0);
      end
      rand_mode = 1'b0;
      tick();
      rstN = 1'b1;
      repeat (3) tick();
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/serial_mux_tx.md
Name: serial_mux_tx

Overview:
Four-channel parallel-to-serial transmitter. It is the send side of the addressed serial link whose receiver steers incoming serial bits to one of four parallel ports.
A round-robin arbiter grants one channel at a time. The granted channel's word is framed with a start bit and a 2-bit port address, then shifted out MSB-first on a single line. The line idles high.

Parameters:
DATA_W, 8, payload bits per frame
CLKS_PER_BIT, 1, clock cycles each serial bit is held on serOut (≥1)

Ports:
clk  input  1  system clock, rising-edge
rstN  input  1  reset, asynchronous, active-low
chData  input  4*DATA_W  channel words; channel i occupies bits [i*DATA_W +: DATA_W]
chValid  input  4  channel i has a word to send
chReady  output  4  one-hot; word on channel i accepted this cycle
serOut  output  1  serial line; idle = 1
busy  output  1  frame in progress (any state except IDLE)
curChan  output  2  address of the channel currently being sent; holds its last value when idle

Behaviour:
- Clocking and reset
  - One clock domain. Everything except the async reset is updated on the rising edge of clk.
  - While rstN = 0: serOut = 1, busy = 0, chReady = 0, curChan = 0, state = IDLE, rrLast = 3. This takes effect immediately, not on the next edge.
  - Reset asserted mid-frame aborts the frame. The captured word is discarded and never retransmitted.
- Frame format, in transmit order:
  - start bit 0
  - address bits a1, a0 (MSB first)
  - DATA_W data bits, MSB first
  - stop bit 1
  - Total 3 + DATA_W + 1 bits = 12 bits at the default width.
- Arbitration
  - Happens in IDLE only.
  - Search order: (rrLast+1) mod 4, then +2, +3, +4.
  - The first channel found with chValid = 1 wins.
- Handshake
  - chReady is combinational. In IDLE it is asserted only for the winning channel; it is 0 in every other state.
  - A transfer occurs when chValid[i] & chReady[i] are both 1.
  - On the transfer edge: the shift register loads {address, chData[i]}, rrLast ← i, curChan ← i, state → START.
  - Sources must hold chData stable while chValid = 1 and chReady = 0.
- State machine (IDLE, START, ADDR, DATA, STOP):
  - Each non-IDLE state holds each bit for CLKS_PER_BIT cycles, counted by baudCnt.
  - A bit counter steps through the bits of a state. ADDR holds 2 bits; DATA holds DATA_W bits.
  - IDLE → START on transfer.
  - START → ADDR, ADDR → DATA, DATA → STOP: each after its last bit's final cycle.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- serOut
  - serOut is registered and reflects the current state/bit: 1 in IDLE and STOP, 0 in START, the shift-register MSB in ADDR and DATA.
  - Latency: the first start-bit cycle is the cycle after the transfer edge.
- Inter-frame timing
  - The earliest next transfer is the first IDLE cycle after STOP. So the line is high for at least CLKS_PER_BIT+1 cycles between frames.
  - A frame occupies exactly (DATA_W+4)*CLKS_PER_BIT cycles with busy = 1.
- Boundary conditions
  - chValid changes during a frame: ignored. Arbitration re-evaluates in IDLE.
  - No valid channel in IDLE: stays IDLE, serOut = 1, rrLast unchanged.
  - A channel deasserting chValid before being granted is legal. Nothing is sent for it.
  - baudCnt and the bit counter wrap to 0 at each state transition; neither ever exceeds its limit.

Test Plan:
1. Reset release, no valid input, 20 cycles → serOut = 1, busy = 0, chReady = 0 throughout.
2. CLKS_PER_BIT = 1, ch2 sends 0xA5 → chReady = 0100 for one cycle. Then serOut = 0,1,0,1,0,1,0,0,1,0,1,1 on 12 consecutive cycles, busy = 1 for exactly those 12, curChan = 2.
3. All four chValid held high from reset → frames sent in channel order 0,1,2,3,0. Each chReady pulses once per frame.
4. Send ch1, then ch1 and ch3 both valid in the next IDLE → ch3 granted first, then ch1.
5. CLKS_PER_BIT = 3, ch0 sends 0xFF → each bit held for 3 cycles, busy = 1 for 36 cycles, address bits 0,0.
6. rstN pulsed low during the DATA state of a ch3 frame → serOut = 1 immediately. After release, no remainder of the frame is sent, and ch0 is granted first if valid.
